// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out converter from W-bit words to a
// 1-bit-per-cycle stream with valid/ready on both sides. Back-to-back words
// stream with no idle cycle between them.
// Optional build macro WORD_SERIALIZER_INVERT_EN: drives the inverse of the
// selected shift-register bit onto down_data, using a 2:1 mux with constant
// data inputs. Handshake and down_last are identical in both builds.

`ifdef WORD_SERIALIZER_INVERT_EN
// Single-bit 2:1 mux; wired as an inverter by tying d0=1, d1=0.
module word_serializer_mux2 (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);
   assign y = sel ? d1 : d0;
endmodule
`endif

module word_serializer #(
   parameter int W         = 8,
   parameter int LSB_FIRST = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         down_valid,
   input  logic         down_ready,
   output logic         down_data,
   output logic         down_last
);
   localparam int            CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic shifting, at_last, accept, xfer, sel_bit;

   assign shifting   = (state_q == SHIFT);
   assign at_last    = shifting && (cnt_q == '0);
   // Ready depends only on state and down_ready, never on up_valid.
   assign up_ready   = (state_q == IDLE) || (at_last && down_ready);
   assign accept     = up_valid && up_ready;
   assign down_valid = shifting;
   assign xfer       = down_valid && down_ready;
   assign down_last  = at_last;
   assign sel_bit    = (LSB_FIRST != 0) ? sr_q[0] : sr_q[W-1];

`ifdef WORD_SERIALIZER_INVERT_EN
   logic inv_bit;
   word_serializer_mux2 u_inv (
      .d0  (1'b1),
      .d1  (1'b0),
      .sel (sel_bit),
      .y   (inv_bit)
   );
   // Gated with SHIFT so the line rests at 0 while idle.
   assign down_data = shifting & inv_bit;
`else
   // Gated with SHIFT: sr may still hold the last bit after returning to IDLE.
   assign down_data = shifting & sel_bit;
`endif

   // Next-state: load on accept (also covers reload on the last bit), shift on
   // transfer, otherwise hold (which keeps outputs stable under backpressure).
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      if (accept) begin
         sr_d    = up_data;
         cnt_d   = CNT_LAST;
         state_d = SHIFT;
      end else if (xfer) begin
         if (cnt_q != '0) begin
            sr_d  = (LSB_FIRST != 0) ? (sr_q >> 1) : (sr_q << 1);
            cnt_d = cnt_q - CW'(1);
         end else begin
            state_d = IDLE;
         end
      end
   end

   // State registers with synchronous reset; a reset mid-word drops the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three instances (W=8 MSB-first, W=8 LSB-first,
// W=1) share handshake inputs. A word-level model (word, bits emitted so far)
// predicts every output each cycle; directed phases pin literal bit streams.
module tb_word_serializer;
`ifdef WORD_SERIALIZER_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   localparam int NI = 3;
   int WI   [NI] = '{8, 8, 1};
   int LSBI [NI] = '{0, 1, 0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic up_valid = 1'b0;
   logic down_ready = 1'b1;
   logic [7:0] up_data = 8'h00;
   logic [NI-1:0] ur, dv, dd, dl;

   always #5 clk = ~clk;

   word_serializer #(.W(8), .LSB_FIRST(0)) u_m (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(ur[0]), .up_data(up_data),
      .down_valid(dv[0]), .down_ready(down_ready), .down_data(dd[0]), .down_last(dl[0]));
   word_serializer #(.W(8), .LSB_FIRST(1)) u_l (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(ur[1]), .up_data(up_data),
      .down_valid(dv[1]), .down_ready(down_ready), .down_data(dd[1]), .down_last(dl[1]));
   word_serializer #(.W(1), .LSB_FIRST(0)) u_1 (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(ur[2]), .up_data(up_data[0]),
      .down_valid(dv[2]), .down_ready(down_ready), .down_data(dd[2]), .down_last(dl[2]));

   // ---------------- behavioural model ----------------
   bit         busy [NI];
   int         emt  [NI];
   logic [7:0] wrd  [NI];

   function automatic logic m_bit(int i);
      int idx;
      idx = (LSBI[i] != 0) ? emt[i] : WI[i] - 1 - emt[i];
      return wrd[i][idx];
   endfunction
   function automatic logic m_valid(int i); return busy[i]; endfunction
   function automatic logic m_last(int i); return busy[i] && (emt[i] == WI[i] - 1); endfunction
   function automatic logic m_data(int i); return busy[i] ? (m_bit(i) ^ INV) : 1'b0; endfunction
   function automatic logic m_ready(int i);
      return !busy[i] || ((emt[i] == WI[i] - 1) && down_ready);
   endfunction

   always @(posedge clk) begin
      bit rdy;
      for (int i = 0; i < NI; i++) begin
         rdy = m_ready(i);
         if (rst) begin
            busy[i] = 1'b0; emt[i] = 0;
         end else begin
            if (busy[i] && down_ready) begin
               emt[i]++;
               if (emt[i] == WI[i]) begin busy[i] = 1'b0; emt[i] = 0; end
            end
            if (up_valid && rdy) begin busy[i] = 1'b1; emt[i] = 0; wrd[i] = up_data; end
         end
      end
   end

   // ---------------- transfer history (for literal pins) ----------------
   logic [63:0] hist [NI];
   logic [63:0] lh   [NI];
   int          ntx  [NI];
   int          cyc = 0;
   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < NI; i++)
         if (!rst && dv[i] && down_ready) begin
            hist[i] = {hist[i][62:0], dd[i]};
            lh[i]   = {lh[i][62:0], dl[i]};
            ntx[i]++;
         end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;
   logic [NI-1:0] ur_neg;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: compare every output against the model at the falling edge,
   // then return just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      ur_neg = ur;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("i%0d up_ready", i),   64'(ur[i]), 64'(m_ready(i)));
         chk($sformatf("i%0d down_valid", i), 64'(dv[i]), 64'(m_valid(i)));
         chk($sformatf("i%0d down_data", i),  64'(dd[i]), 64'(m_data(i)));
         chk($sformatf("i%0d down_last", i),  64'(dl[i]), 64'(m_last(i)));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input int inst);
      int n;
      up_valid = 1'b1;
      up_data  = d;
      n = 0;
      do begin tick(); n++; end while (!ur_neg[inst] && n < 200);
      chk($sformatf("accept timeout i%0d", inst), 64'(ur_neg[inst]), 64'd1);
   endtask

   task automatic wait_cyc(input int c0, input int len);
      int n;
      n = 0;
      while ((cyc - c0) < len && n < 200) begin tick(); n++; end
   endtask

   task automatic settle();
      up_valid = 1'b0; down_ready = 1'b1;
      for (int k = 0; k < 10; k++) tick();
   endtask

   initial begin
      int c0, n0;
      for (int i = 0; i < NI; i++) begin
         busy[i] = 1'b0; emt[i] = 0; wrd[i] = '0; hist[i] = '0; lh[i] = '0; ntx[i] = 0;
      end
      // reset
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset i%0d valid", i), 64'(dv[i]), 64'd0);
         chk($sformatf("reset i%0d data", i),  64'(dd[i]), 64'd0);
         chk($sformatf("reset i%0d last", i),  64'(dl[i]), 64'd0);
         chk($sformatf("reset i%0d ready", i), 64'(ur[i]), 64'd1);
      end

      // single word, MSB-first
      c0 = cyc; n0 = ntx[0];
      send(8'hA5, 0); up_valid = 1'b0;
      wait_cyc(c0, 9);
      chk("single cnt",  64'(ntx[0] - n0), 64'd8);
      chk("single bits", 64'(hist[0][7:0]), 64'(8'hA5 ^ {8{INV}}));
      chk("single last", 64'(lh[0][7:0]), 64'h01);
      chk("single idle ready", 64'(ur[0]), 64'd1);
      settle();

      // back-to-back words
      c0 = cyc; n0 = ntx[0];
      send(8'hA5, 0);
      send(8'h3C, 0); up_valid = 1'b0;
      wait_cyc(c0, 17);
      chk("b2b cnt",  64'(ntx[0] - n0), 64'd16);
      chk("b2b bits", 64'(hist[0][15:0]), 64'(16'hA53C ^ {16{INV}}));
      chk("b2b last", 64'(lh[0][15:0]), 64'h0101);
      settle();

      // backpressure: down_ready alternating 0,1
      down_ready = 1'b0;
      n0 = ntx[0];
      send(8'hA5, 0); up_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin down_ready = (k % 2) != 0; tick(); end
      chk("bp cnt",  64'(ntx[0] - n0), 64'd8);
      chk("bp bits", 64'(hist[0][7:0]), 64'(8'hA5 ^ {8{INV}}));
      chk("bp last", 64'(lh[0][7:0]), 64'h01);
      settle();

      // reset mid-word, then 8'hFF
      send(8'hA5, 0); up_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst valid", 64'(dv[0]), 64'd0);
      chk("midrst ready", 64'(ur[0]), 64'd1);
      c0 = cyc; n0 = ntx[0];
      send(8'hFF, 0); up_valid = 1'b0;
      wait_cyc(c0, 9);
      chk("ff cnt",  64'(ntx[0] - n0), 64'd8);
      chk("ff bits", 64'(hist[0][7:0]), 64'(8'hFF ^ {8{INV}}));
      chk("ff last", 64'(lh[0][7:0]), 64'h01);
      settle();

      // LSB-first
      c0 = cyc; n0 = ntx[1];
      send(8'h01, 1); up_valid = 1'b0;
      wait_cyc(c0, 9);
      chk("lsb cnt",  64'(ntx[1] - n0), 64'd8);
      chk("lsb bits", 64'(hist[1][7:0]), 64'(8'h80 ^ {8{INV}}));
      chk("lsb last", 64'(lh[1][7:0]), 64'h01);
      settle();

      // W=1 back-to-back 1,0,1
      n0 = ntx[2];
      send(8'h01, 2);
      send(8'h00, 2);
      send(8'h01, 2); up_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("w1 cnt",  64'(ntx[2] - n0), 64'd3);
      chk("w1 bits", 64'(hist[2][2:0]), 64'(3'b101 ^ {3{INV}}));
      chk("w1 last", 64'(lh[2][2:0]), 64'h7);
      settle();

      // randomized traffic, occasional reset
      for (int k = 0; k < 3000; k++) begin
         up_valid   = ($urandom_range(0, 3) != 0);
         up_data    = 8'($urandom);
         down_ready = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
